// File: rtl/video_blitter_pkg.sv
// Shared constants and types for the Kangaroo video-board blitter.
// Register offsets on AB[3:0], FLAGS bit positions and the copy FSM state type.
package video_blitter_pkg;

  localparam logic [3:0] REG_SRC_L  = 4'd0;
  localparam logic [3:0] REG_SRC_H  = 4'd1;
  localparam logic [3:0] REG_DST_L  = 4'd2;
  localparam logic [3:0] REG_DST_H  = 4'd3;
  localparam logic [3:0] REG_HEIGHT = 4'd4;
  localparam logic [3:0] REG_WIDTH  = 4'd5;
  localparam logic [3:0] REG_FLAGS  = 4'd8;

  localparam int FLAG_PLANE_LSB = 0;
  localparam int FLAG_PLANE_MSB = 3;
  localparam int FLAG_BANK      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } blit_state_t;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  height;
    logic [7:0]  width;
    logic [7:0]  flags;
  } blit_regs_t;

endpackage

// File: rtl/video_blitter_if.sv
// CPU-side strobes/data bus plus graphics ROM and video RAM ports of the blitter.
// slave = blitter view, master = CPU board / memory side view.
interface video_blitter_if #(
  parameter int ADDR_W = 14
) ();

  logic              BLIT_CS_AL;
  logic              MW_AL;
  logic [3:0]        AB;
  logic [7:0]        DB;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic              ROM_RD;
  logic [7:0]        ROM_DATA;
  logic [ADDR_W-1:0] VRAM_ADDR;
  logic [7:0]        VRAM_DATA;
  logic              VRAM_WE;
  logic [3:0]        VRAM_PLANE_EN;
  logic              BUSY;

  modport slave (
    input  BLIT_CS_AL, MW_AL, AB, DB, ROM_DATA,
    output ROM_ADDR, ROM_RD, VRAM_ADDR, VRAM_DATA, VRAM_WE, VRAM_PLANE_EN, BUSY
  );

  modport master (
    output BLIT_CS_AL, MW_AL, AB, DB, ROM_DATA,
    input  ROM_ADDR, ROM_RD, VRAM_ADDR, VRAM_DATA, VRAM_WE, VRAM_PLANE_EN, BUSY
  );

endinterface

// File: rtl/video_blitter_regs.sv
// Blitter register file: registered CPU write strobe with rising-edge detect,
// so a strobe held for many cycles produces exactly one register write.
module video_blitter_regs
  import video_blitter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       blit_cs_al,
  input  logic       mw_al,
  input  logic [3:0] ab,
  input  logic [7:0] db,
  input  logic       busy,
  output blit_regs_t regs,
  output logic       trigger
);

  logic       wr_q;
  logic       wr_q_d;
  logic [3:0] ab_q;
  logic [7:0] db_q;
  logic       wr_event;

  // Address and data are registered alongside the strobe so they line up with it.
  assign wr_event = wr_q && !wr_q_d && !busy;
  assign trigger  = wr_event && (ab_q == REG_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      wr_q_d <= 1'b0;
      ab_q   <= '0;
      db_q   <= '0;
      regs   <= '0;
    end else begin
      wr_q   <= !blit_cs_al && !mw_al;
      wr_q_d <= wr_q;
      ab_q   <= ab;
      db_q   <= db;
      if (wr_event) begin
        case (ab_q)
          REG_SRC_L:  regs.src[7:0]  <= db_q;
          REG_SRC_H:  regs.src[15:8] <= db_q;
          REG_DST_L:  regs.dst[7:0]  <= db_q;
          REG_DST_H:  regs.dst[15:8] <= db_q;
          REG_HEIGHT: regs.height    <= db_q;
          REG_WIDTH:  regs.width     <= db_q;
          REG_FLAGS:  regs.flags     <= db_q;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: rtl/video_blitter.sv
// Kangaroo video-board blitter: rectangular copy from graphics ROM into video RAM,
// launched by a write to the WIDTH register.
//
//   state | meaning
//   IDLE  | waiting for a WIDTH write; BUSY low
//   FETCH | ROM read of src_ptr (bank bit from FLAGS)
//   WRITE | ROM byte written to VRAM at dst_ptr, pointers/counters advance
module video_blitter
  import video_blitter_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DST_STRIDE = 256
) (
  input  logic            CPU_CLOCK,
  input  logic            FPGA_RESET,
  video_blitter_if.slave  bus
);

  localparam logic [15:0] STRIDE = 16'(DST_STRIDE);

  blit_state_t state;
  blit_regs_t  regs;
  logic        trigger;
  logic        busy;
  logic [15:0] src_ptr;
  logic [15:0] dst_ptr;
  logic [15:0] row_start;
  logic [8:0]  col;
  logic [8:0]  row;

  assign busy = (state != IDLE);

  video_blitter_regs u_regs (
    .clk        (CPU_CLOCK),
    .rst        (FPGA_RESET),
    .blit_cs_al (bus.BLIT_CS_AL),
    .mw_al      (bus.MW_AL),
    .ab         (bus.AB),
    .db         (bus.DB),
    .busy       (busy),
    .regs       (regs),
    .trigger    (trigger)
  );

  always_ff @(posedge CPU_CLOCK) begin
    if (FPGA_RESET) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      row_start <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= FETCH;
            src_ptr   <= regs.src;
            dst_ptr   <= regs.dst;
            row_start <= regs.dst;
            col       <= '0;
            row       <= '0;
          end
        end
        FETCH: state <= WRITE;
        WRITE: begin
          src_ptr <= src_ptr + 16'd1;
          if (col < {1'b0, regs.width}) begin
            col     <= col + 9'd1;
            dst_ptr <= dst_ptr + 16'd1;
            state   <= FETCH;
          end else if (row < {1'b0, regs.height}) begin
            row       <= row + 9'd1;
            col       <= '0;
            row_start <= row_start + STRIDE;
            dst_ptr   <= row_start + STRIDE;
            state     <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses and data are gated so the buses sit at zero outside their cycle.
  always_comb begin
    bus.ROM_RD    = (state == FETCH);
    bus.VRAM_WE   = (state == WRITE);
    bus.ROM_ADDR  = '0;
    bus.VRAM_ADDR = '0;
    bus.VRAM_DATA = '0;
    if (state == FETCH) begin
      bus.ROM_ADDR = {regs.flags[FLAG_BANK], src_ptr[ADDR_W-2:0]};
    end
    if (state == WRITE) begin
      bus.VRAM_ADDR = dst_ptr[ADDR_W-1:0];
      bus.VRAM_DATA = bus.ROM_DATA;
    end
  end

  assign bus.VRAM_PLANE_EN = regs.flags[FLAG_PLANE_MSB:FLAG_PLANE_LSB];
  assign bus.BUSY          = busy;

  logic unused_bits;
  assign unused_bits = ^{src_ptr[15:ADDR_W-1], dst_ptr[15:ADDR_W], regs.flags[7:6], regs.flags[4]};

endmodule

// File: tb/tb_video_blitter.sv
// Directed bench for video_blitter: CPU register writes, behavioural graphics ROM,
// and a negedge monitor logging every ROM read and VRAM write.
module tb_video_blitter;
  import video_blitter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [13:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [13:0] rom_log[$];
  int          busy_cnt;
  int          overlap;

  video_blitter_if #(.ADDR_W(14)) bus ();

  video_blitter #(.ADDR_W(14), .DST_STRIDE(256)) dut (
    .CPU_CLOCK  (clk),
    .FPGA_RESET (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
  endfunction

  // Synchronous graphics ROM: data valid the cycle after ROM_RD.
  always @(posedge clk) begin
    bus.ROM_DATA <= bus.ROM_RD ? rom_byte(bus.ROM_ADDR) : 8'h00;
  end

  always @(negedge clk) begin
    if (bus.VRAM_WE) begin
      wr_addr.push_back(bus.VRAM_ADDR);
      wr_data.push_back(bus.VRAM_DATA);
    end
    if (bus.ROM_RD) rom_log.push_back(bus.ROM_ADDR);
    if (bus.BUSY) busy_cnt++;
    if (bus.ROM_RD && bus.VRAM_WE) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.AB = a;
    bus.DB = d;
    bus.BLIT_CS_AL = 1'b0;
    bus.MW_AL = 1'b0;
    repeat (2) @(negedge clk);
    bus.BLIT_CS_AL = 1'b1;
    bus.MW_AL = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    rom_log.delete();
    busy_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.BUSY && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.BUSY}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [13:0] exp_3x2[6] = '{14'h0400, 14'h0401, 14'h0402, 14'h0500, 14'h0501, 14'h0502};

  initial begin
    checks = 0;
    errors = 0;
    overlap = 0;
    busy_cnt = 0;
    rst = 1'b1;
    bus.BLIT_CS_AL = 1'b1;
    bus.MW_AL = 1'b1;
    bus.AB = 4'h0;
    bus.DB = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_strobes", {30'd0, bus.ROM_RD, bus.VRAM_WE}, 32'd0);
    check("rst_rom_addr", {18'd0, bus.ROM_ADDR}, 32'd0);
    check("rst_vram_addr", {18'd0, bus.VRAM_ADDR}, 32'd0);
    check("rst_vram_data_plane", {20'd0, bus.VRAM_DATA, bus.VRAM_PLANE_EN}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Strobe held low for 5 cycles: only the first HEIGHT value may land
    @(negedge clk);
    bus.AB = REG_HEIGHT;
    bus.DB = 8'h01;
    bus.BLIT_CS_AL = 1'b0;
    bus.MW_AL = 1'b0;
    @(negedge clk);
    bus.DB = 8'h07;
    repeat (4) @(negedge clk);
    bus.BLIT_CS_AL = 1'b1;
    bus.MW_AL = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h00);
    wait_idle("held_idle", 50);
    check("held_busy_cycles", busy_cnt, 32'd4);
    check("held_writes", wr_addr.size(), 32'd2);
    check("held_row2_addr", {18'd0, wr_addr[1]}, 32'h0100);

    // 1x1 copy
    cpu_write(REG_SRC_L, 8'h10);
    cpu_write(REG_SRC_H, 8'h00);
    cpu_write(REG_DST_L, 8'h00);
    cpu_write(REG_DST_H, 8'h02);
    cpu_write(REG_FLAGS, 8'h0F);
    cpu_write(REG_HEIGHT, 8'h00);
    check("plane_en", {28'd0, bus.VRAM_PLANE_EN}, 32'hF);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h00);
    wait_idle("1x1_idle", 50);
    check("1x1_busy_cycles", busy_cnt, 32'd2);
    check("1x1_writes", wr_addr.size(), 32'd1);
    check("1x1_rom_addr", {18'd0, rom_log[0]}, 32'h0010);
    check("1x1_vram_addr", {18'd0, wr_addr[0]}, 32'h0200);
    check("1x1_vram_data", {24'd0, wr_data[0]}, {24'd0, rom_byte(14'h0010)});

    // 3x2 copy
    cpu_write(REG_SRC_L, 8'h00);
    cpu_write(REG_SRC_H, 8'h01);
    cpu_write(REG_DST_H, 8'h04);
    cpu_write(REG_HEIGHT, 8'h01);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h02);
    wait_idle("3x2_idle", 50);
    check("3x2_busy_cycles", busy_cnt, 32'd12);
    check("3x2_writes", wr_addr.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("3x2_vram_addr[%0d]", i), {18'd0, wr_addr[i]}, {18'd0, exp_3x2[i]});
      check($sformatf("3x2_rom_addr[%0d]", i), {18'd0, rom_log[i]}, 32'h0100 + i);
      check($sformatf("3x2_data[%0d]", i), {24'd0, wr_data[i]},
            {24'd0, rom_byte(14'h0100 + 14'(i))});
    end

    // Bank select
    cpu_write(REG_FLAGS, 8'h20);
    cpu_write(REG_SRC_L, 8'h03);
    cpu_write(REG_SRC_H, 8'h00);
    cpu_write(REG_HEIGHT, 8'h00);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h00);
    wait_idle("bank_idle", 50);
    check("bank_rom_addr", {18'd0, rom_log[0]}, 32'h2003);
    check("bank_data", {24'd0, wr_data[0]}, {24'd0, rom_byte(14'h2003)});
    check("bank_plane_en", {28'd0, bus.VRAM_PLANE_EN}, 32'h0);

    // Busy lockout during a 4x4 copy
    cpu_write(REG_FLAGS, 8'h0F);
    cpu_write(REG_SRC_L, 8'h00);
    cpu_write(REG_SRC_H, 8'h02);
    cpu_write(REG_DST_L, 8'h00);
    cpu_write(REG_DST_H, 8'h08);
    cpu_write(REG_HEIGHT, 8'h03);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h03);
    cpu_write(REG_DST_L, 8'hFF);
    cpu_write(REG_WIDTH, 8'h00);
    wait_idle("lock_idle", 100);
    check("lock_busy_cycles", busy_cnt, 32'd32);
    check("lock_writes", wr_addr.size(), 32'd16);
    check("lock_row1_addr", {18'd0, wr_addr[4]}, 32'h0900);
    check("lock_last_addr", {18'd0, wr_addr[15]}, 32'h0B03);
    check("lock_last_rom", {18'd0, rom_log[15]}, 32'h020F);
    cpu_write(REG_HEIGHT, 8'h00);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h00);
    wait_idle("lock_after_idle", 50);
    check("lock_dst_l_kept", {18'd0, wr_addr[0]}, 32'h0800);

    // Mid-copy reset after the 3rd VRAM write
    cpu_write(REG_HEIGHT, 8'h03);
    clear_logs();
    cpu_write(REG_WIDTH, 8'h03);
    begin
      int n = 0;
      while (wr_addr.size() < 3 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    check("midrst_reached", wr_addr.size(), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("midrst_we", {31'd0, bus.VRAM_WE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_more_writes", wr_addr.size(), 32'd3);
    check("midrst_still_idle", {31'd0, bus.BUSY}, 32'd0);

    // 256-wide row from SRC=0xFFFF: source wraps to 0x0000
    cpu_write(REG_SRC_L, 8'hFF);
    cpu_write(REG_SRC_H, 8'hFF);
    cpu_write(REG_DST_L, 8'h00);
    cpu_write(REG_DST_H, 8'h1F);
    cpu_write(REG_HEIGHT, 8'h00);
    clear_logs();
    cpu_write(REG_WIDTH, 8'hFF);
    wait_idle("wide_idle", 700);
    check("wide_busy_cycles", busy_cnt, 32'd512);
    check("wide_writes", wr_addr.size(), 32'd256);
    check("wide_rom_first", {18'd0, rom_log[0]}, 32'h1FFF);
    check("wide_rom_wrap", {18'd0, rom_log[1]}, 32'h0000);
    check("wide_rom_last", {18'd0, rom_log[255]}, 32'h00FE);
    check("wide_vram_first", {18'd0, wr_addr[0]}, 32'h1F00);
    check("wide_vram_last", {18'd0, wr_addr[255]}, 32'h1FFF);
    check("wide_data_wrap", {24'd0, wr_data[1]}, {24'd0, rom_byte(14'h0000)});

    check("rd_we_overlap", overlap, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_blitter.md
Name: video_blitter

Overview:
- Kangaroo video-board blitter; it is the downstream consumer of the CPU board's CN1 blitter/video control strobes and data bus DB.
- The CPU programs source, destination, size and flags registers. A write to the width register launches a rectangular copy from graphics ROM into video RAM.
- While the copy runs, the blitter owns the graphics ROM and video RAM write ports and raises BUSY.

Parameters:
- ADDR_W, 14, width of ROM_ADDR and VRAM_ADDR.
- DST_STRIDE, 256, destination address increment per row.

Ports:
- CPU_CLOCK  in  1  single system clock; all logic is on the rising edge.
- FPGA_RESET  in  1  synchronous, active-high reset.
- BLIT_CS_AL  in  1  blitter register select from CPU address decode, active low.
- MW_AL  in  1  CPU memory write strobe, active low.
- AB  in  4  CPU address bits [3:0]; selects the register.
- DB  in  8  CPU data bus.
- ROM_ADDR  out  ADDR_W  graphics ROM address.
- ROM_RD  out  1  graphics ROM read enable.
- ROM_DATA  in  8  graphics ROM data; valid 1 cycle after ROM_RD.
- VRAM_ADDR  out  ADDR_W  video RAM write address.
- VRAM_DATA  out  8  video RAM write data.
- VRAM_WE  out  1  video RAM write enable, one-cycle pulse per byte.
- VRAM_PLANE_EN  out  4  plane write mask (flags[3:0]).
- BUSY  out  1  high while a copy is in progress.

Behaviour:
- Register write strobe:
  - WR = !BLIT_CS_AL && !MW_AL, registered once.
  - A write occurs on the first cycle WR is high after being low: one write per strobe pulse, however long the pulse lasts.
- Register map by AB:
  - 0 = SRC_L, 1 = SRC_H.
  - 2 = DST_L, 3 = DST_H.
  - 4 = HEIGHT.
  - 5 = WIDTH; writing it also triggers the copy.
  - 8 = FLAGS: [3:0] plane enable, [5] ROM bank.
  - Any other offset is ignored.
- Reset:
  - All registers are 0, state is IDLE, BUSY=0, ROM_RD=0, VRAM_WE=0.
  - ROM_ADDR, VRAM_ADDR and VRAM_DATA are 0; VRAM_PLANE_EN is 0.
  - FPGA_RESET mid-copy aborts the copy next edge with no further VRAM_WE.
- Size arithmetic:
  - Effective width W = WIDTH+1 and height H = HEIGHT+1, each in the range 1..256.
  - The working counters are 9 bits wide.
- States:
  - IDLE -> FETCH on a trigger write; BUSY is high from the next cycle. The working copies src_ptr=SRC, row_start=DST, dst_ptr=DST, col=0, row=0 are loaded at that point.
  - FETCH (1 cycle): ROM_RD=1, ROM_ADDR={FLAGS[5], src_ptr[ADDR_W-2:0]}. Go to WRITE.
  - WRITE (1 cycle): VRAM_WE=1, VRAM_DATA=ROM_DATA, VRAM_ADDR=dst_ptr[ADDR_W-1:0]. Then src_ptr+=1.
    - If col<W-1: col+=1, dst_ptr+=1, go to FETCH.
    - Else if row<H-1: row+=1, col=0, row_start+=DST_STRIDE, dst_ptr=row_start+DST_STRIDE, go to FETCH.
    - Else go to IDLE and clear BUSY on that edge.
- Timing and address wrap:
  - Copy length is exactly 2*W*H cycles with BUSY high.
  - src_ptr and dst_ptr are 16 bits and wrap modulo 2^16; only the low bits are driven out.
- Writes during a copy:
  - Register writes while BUSY are ignored, including WIDTH; there is no retrigger.
  - A trigger write on the same edge as the final WRITE is also ignored.
- ROM_RD and VRAM_WE are never high in the same cycle.
- VRAM_PLANE_EN follows FLAGS[3:0] continuously.

Decomposition:
- video_blitter_pkg holds:
  - the register offset constants REG_SRC_L..REG_FLAGS;
  - the typedef enum blit_state_t {IDLE, FETCH, WRITE};
  - the FLAGS bit positions.
- One sub-module, video_blitter_regs: write-strobe edge detect, register file and trigger pulse output.
- The copy FSM and counters stay in video_blitter.

Test Plan:
- Reset check: assert FPGA_RESET 2 cycles -> all outputs 0 and BUSY=0; hold MW_AL low for 5 cycles with AB=4 -> only one HEIGHT write occurs.
- 1x1 copy: SRC=0x0010, DST=0x0200, FLAGS=0x0F, HEIGHT=0, then WIDTH=0 -> BUSY high for 2 cycles. ROM_ADDR=0x0010, then one VRAM_WE at VRAM_ADDR=0x0200 with the ROM byte; VRAM_PLANE_EN=0xF.
- 3x2 copy: SRC=0x0100, DST=0x0400, HEIGHT=1, WIDTH=2 -> 12 busy cycles.
  - VRAM_ADDR sequence is 0x400, 0x401, 0x402, 0x500, 0x501, 0x502.
  - ROM_ADDR runs 0x100..0x105.
- Bank select: FLAGS=0x20, SRC=0x0003 -> ROM_ADDR=0x2003.
- Busy lockout: during a 4x4 copy, write DST_L=0xFF and WIDTH=0 -> the copy completes at 32 cycles with the original addresses, and DST_L is unchanged afterwards.
- Mid-copy reset and boundaries:
  - Assert FPGA_RESET after the 3rd VRAM_WE -> no further VRAM_WE and BUSY=0 next cycle.
  - WIDTH=255, HEIGHT=0 from SRC=0xFFFF -> 256 writes, with src wrapping to 0x0000.
